// File: rtl/audio_volume_meter.sv
// Windowed peak detector and 0..15 volume quantiser with peak-hold decay,
// driving registered level, thermometer LED bar and decimal digits.
module audio_volume_meter #(
    parameter int WINDOW_LEN   = 10000,
    parameter int BASE         = 2175,
    parameter int STEP_SHIFT   = 7,
    parameter int HOLD_WINDOWS = 4
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [11:0] sample,
    output logic [4:0]  volume,
    output logic [15:0] led_bar,
    output logic        tens,
    output logic [3:0]  ones,
    output logic        level_valid
);

    localparam int CNT_W  = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
    localparam int HOLD_W = (HOLD_WINDOWS > 1) ? $clog2(HOLD_WINDOWS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WINDOW_LEN - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_WINDOWS - 1);
    localparam logic [12:0]       BASE13    = 13'(BASE);

    // accumulate stage
    logic [CNT_W-1:0] win_cnt_reg;
    logic [11:0]      run_max_reg;
    logic [11:0]      peak_cand;
    // eval stage
    logic             eval_valid_reg;
    logic [11:0]      eval_peak_reg;
    logic [12:0]      peak13;
    logic [12:0]      diff13;
    logic [12:0]      quot13;
    logic [4:0]       level_next;
    // update stage
    logic             upd_valid_reg;
    logic [4:0]       upd_level_reg;
    logic [4:0]       volume_reg;
    logic [4:0]       volume_next;
    logic [HOLD_W-1:0] hold_reg;
    logic [HOLD_W-1:0] hold_next;
    logic [15:0]      led_bar_reg;
    logic [15:0]      led_bar_next;
    logic             tens_reg;
    logic             tens_next;
    logic [3:0]       ones_reg;
    logic [3:0]       ones_next;
    logic             level_valid_reg;

    // The first sample of a window replaces the stale max rather than competing with it.
    always_comb begin
        peak_cand = sample;
        if (win_cnt_reg != '0 && run_max_reg > sample) begin
            peak_cand = run_max_reg;
        end
    end

    always_comb begin
        peak13     = {1'b0, eval_peak_reg};
        diff13     = '0;
        quot13     = '0;
        level_next = '0;
        if (peak13 > BASE13) begin
            diff13 = peak13 - BASE13 - 13'd1;
            quot13 = diff13 >> STEP_SHIFT;
            level_next = (quot13 >= 13'd15) ? 5'd15 : 5'(quot13) + 5'd1;
        end
    end

    always_comb begin
        volume_next = volume_reg;
        hold_next   = hold_reg;
        if (upd_valid_reg) begin
            if (upd_level_reg >= volume_reg) begin
                volume_next = upd_level_reg;
                hold_next   = '0;
            end else if (hold_reg == HOLD_LAST) begin
                volume_next = volume_reg - 5'd1;
                hold_next   = '0;
            end else begin
                hold_next = hold_reg + HOLD_W'(1);
            end
        end
    end

    for (genvar gi = 0; gi < 16; gi++) begin : g_led
        assign led_bar_next[gi] = (5'(gi) <= volume_next);
    end

    always_comb begin
        tens_next = (volume_next >= 5'd10);
        ones_next = tens_next ? 4'(volume_next - 5'd10) : volume_next[3:0];
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            win_cnt_reg     <= '0;
            run_max_reg     <= '0;
            eval_valid_reg  <= 1'b0;
            eval_peak_reg   <= '0;
            upd_valid_reg   <= 1'b0;
            upd_level_reg   <= '0;
            volume_reg      <= '0;
            hold_reg        <= '0;
            led_bar_reg     <= 16'h0001;
            tens_reg        <= 1'b0;
            ones_reg        <= '0;
            level_valid_reg <= 1'b0;
        end else begin
            eval_valid_reg <= 1'b0;
            if (sample_valid) begin
                if (win_cnt_reg == CNT_LAST) begin
                    win_cnt_reg    <= '0;
                    eval_peak_reg  <= peak_cand;
                    eval_valid_reg <= 1'b1;
                end else begin
                    win_cnt_reg <= win_cnt_reg + CNT_W'(1);
                end
                run_max_reg <= peak_cand;
            end
            upd_valid_reg   <= eval_valid_reg;
            upd_level_reg   <= level_next;
            volume_reg      <= volume_next;
            hold_reg        <= hold_next;
            led_bar_reg     <= led_bar_next;
            tens_reg        <= tens_next;
            ones_reg        <= ones_next;
            level_valid_reg <= upd_valid_reg;
        end
    end

    assign volume      = volume_reg;
    assign led_bar     = led_bar_reg;
    assign tens        = tens_reg;
    assign ones        = ones_reg;
    assign level_valid = level_valid_reg;

endmodule

// File: doc/audio_volume_meter.md
Name: audio_volume_meter

Overview:
- Sits directly upstream of the volume displays (LED bar, 7-segment, OLED volume bar, game).
- Consumes 12-bit mic samples from the audio capture stage, qualified by a one-cycle valid strobe.
- Finds the peak amplitude over fixed windows of samples and quantises it to a 0..15 volume level.
- Applies peak-hold with stepwise decay, and drives registered level, LED bar and decimal-digit outputs for the display stages.

Parameters:
- WINDOW_LEN, 10000: number of valid samples per peak window (>=1).
- BASE, 2175: peak values at or below this map to level 0.
- STEP_SHIFT, 7: log2 of amplitude step per level (128 codes per level).
- HOLD_WINDOWS, 4: windows a held level persists before decaying by 1 (>=1).

Ports:
- CLK  in  1  100 MHz system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- sample_valid  in  1  one-cycle strobe: sample is valid this cycle.
- sample  in  12  unsigned mic sample, 0..4095.
- volume  out  5  held volume level, 0..15.
- led_bar  out  16  thermometer code of volume.
- tens  out  1  decimal tens digit of volume (0 or 1).
- ones  out  4  decimal ones digit of volume (0..9).
- level_valid  out  1  one-cycle pulse when outputs update.

Behaviour:
- One clock (CLK); reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - volume=0, led_bar=16'h0001, tens=0, ones=0, level_valid=0.
  - Window counter=0, running max=0, hold counter=0, pipeline stages empty.
  - Reset mid-window discards the partial window.
  - Reset during EVAL/UPDATE cancels the pending update; no level_valid pulse is emitted.
- Accumulate stage:
  - On each sample_valid, running max <= (first sample of window) ? sample : max(running max, sample).
  - Window counter increments on each sample_valid.
  - When the counter reaches WINDOW_LEN-1 on a valid sample, that sample is included in the peak.
  - On that cycle the counter wraps to 0, the final peak is latched into the EVAL register, and the next valid sample starts a fresh window.
  - Cycles without sample_valid hold all accumulate state.
- EVAL stage (cycle after window close):
  - level = 0 if peak <= BASE.
  - Otherwise level = ((peak-BASE-1) >> STEP_SHIFT) + 1, saturated at 15.
  - Use 13-bit unsigned arithmetic; no negative intermediates.
  - Defaults: 2175->0, 2176->1, 2303->1, 2304->2, 3327->9, 3328->10, 4095->15.
- UPDATE stage (cycle after EVAL):
  - If level >= volume: volume <= level, hold counter <= 0.
  - Else if hold counter == HOLD_WINDOWS-1: volume <= volume-1, hold counter <= 0. volume never drops below level because level < volume.
  - Else: hold counter increments and volume is unchanged.
  - level_valid pulses high for exactly this one cycle.
- Latency: level_valid and the new outputs appear 2 cycles after the CLK edge that accepts the window-closing sample.
- Pipelining: accumulation continues during EVAL/UPDATE, so a sample_valid in those cycles is accepted normally. With WINDOW_LEN=1 and back-to-back strobes, one update per cycle is sustained.
- Derived outputs:
  - led_bar bits [volume:0] set, all others clear (0 -> 16'h0001, 15 -> 16'hFFFF).
  - tens = (volume>=10); ones = volume - 10*tens.
  - All derived outputs change in the same cycle as volume.

Test Plan:
- Quantiser boundaries: WINDOW_LEN=1, HOLD_WINDOWS=1, single samples 2175, 2176, 2303, 2304, 3328, 4095 spaced 5 cycles apart -> volume 0, 1, 1, 2, 10, 15. led_bar for 10 = 16'h07FF; tens/ones=1/0 for 10 and 1/5 for 15. Each level_valid arrives 2 cycles after its strobe.
- Window peak: WINDOW_LEN=4, samples 2200, 3000, 2500, 2300 -> one level_valid, volume 7 (peak 3000). Next window of four 2100s -> level 0 (decay governed by hold).
- Hold/decay: HOLD_WINDOWS=2, volume at 15, then windows of level 0 -> volume sequence 15, 14, 14, 13, 13, 12 ... on successive level_valid pulses. A window at level 13 mid-decay snaps volume to 13 (if >= current) and clears the hold counter.
- Gapped strobes: WINDOW_LEN=3, sample_valid asserted every 7th cycle, sample=4095 -> exactly one level_valid per 3 strobes, volume 15. No change between strobes.
- Reset mid-operation: assert reset for 1 cycle on the EVAL cycle of a 4095 window -> no level_valid pulse; volume=0, led_bar=16'h0001. A subsequent full window of 2304 -> volume 2.
- Back-to-back: WINDOW_LEN=1, sample_valid held high for 4 cycles with 2176, 2304, 2432, 2560, HOLD_WINDOWS=1 -> four consecutive level_valid pulses with volume 1, 2, 3, 4.
